// File: rtl/decodificador_bcd_7seg.sv
// ---------------------------------------------------------------------------
// decodificador_bcd_7seg
//
// Triple BCD-to-seven-segment decoder for the microwave timer display.
// Three identical, independent channels (minutes, seconds tens, seconds ones)
// each do a combinational BCD lookup followed by a 7-bit output register.
// Latency is one clock; a new digit triple may be presented every cycle.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset (outputs go dark)
//   min            minutes digit, BCD
//   sec_tens       seconds tens digit, BCD (6..9 still decoded)
//   sec_ones       seconds ones digit, BCD
//   min_segs       segment pattern for min,      bits {a,b,c,d,e,f,g} = [6:0]
//   sec_tens_segs  segment pattern for sec_tens, same bit order
//   sec_ones_segs  segment pattern for sec_ones, same bit order
//   bcd_err        high when any input sampled on the previous edge was > 9
//
// Build option:
//   DECODIFICADOR_ACTIVE_LOW_EN  when defined, segment outputs are inverted
//                                for common-anode displays (0 = lit), and the
//                                reset value becomes all ones. bcd_err keeps
//                                its active-high polarity.
// ---------------------------------------------------------------------------
module decodificador_bcd_7seg (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  output logic [6:0] min_segs,
  output logic [6:0] sec_tens_segs,
  output logic [6:0] sec_ones_segs,
  output logic       bcd_err
);

  localparam int unsigned DATA_W = 4;
  localparam int unsigned SEG_W  = 7;

`ifdef DECODIFICADOR_ACTIVE_LOW_EN
  localparam logic [SEG_W-1:0] SEG_DARK = 7'b1111111;
`else
  localparam logic [SEG_W-1:0] SEG_DARK = 7'b0000000;
`endif

  // Active-high lookup; values 10..15 show a dash (segment g only).
  function automatic logic [SEG_W-1:0] bcd_to_segs(input logic [DATA_W-1:0] digit);
    logic [SEG_W-1:0] segs;
    case (digit)
      4'd0:    segs = 7'b1111110;
      4'd1:    segs = 7'b0110000;
      4'd2:    segs = 7'b1101101;
      4'd3:    segs = 7'b1111001;
      4'd4:    segs = 7'b0110011;
      4'd5:    segs = 7'b1011011;
      4'd6:    segs = 7'b1011111;
      4'd7:    segs = 7'b1110000;
      4'd8:    segs = 7'b1111111;
      4'd9:    segs = 7'b1111011;
      default: segs = 7'b0000001;
    endcase
    return segs;
  endfunction

  // Maps the active-high pattern onto the display's drive polarity.
  function automatic logic [SEG_W-1:0] apply_polarity(input logic [SEG_W-1:0] segs);
`ifdef DECODIFICADOR_ACTIVE_LOW_EN
    return ~segs;
`else
    return segs;
`endif
  endfunction

  function automatic logic is_invalid_bcd(input logic [DATA_W-1:0] digit);
    return (digit > 4'd9);
  endfunction

  logic [SEG_W-1:0] min_segs_p0;
  logic [SEG_W-1:0] sec_tens_segs_p0;
  logic [SEG_W-1:0] sec_ones_segs_p0;
  logic             bcd_err_p0;

  logic [SEG_W-1:0] min_segs_p1;
  logic [SEG_W-1:0] sec_tens_segs_p1;
  logic [SEG_W-1:0] sec_ones_segs_p1;
  logic             bcd_err_p1;

  // ---- Stage p0: combinational decode of the raw inputs ----
  always_comb begin
    min_segs_p0      = apply_polarity(bcd_to_segs(min));
    sec_tens_segs_p0 = apply_polarity(bcd_to_segs(sec_tens));
    sec_ones_segs_p0 = apply_polarity(bcd_to_segs(sec_ones));
    bcd_err_p0       = is_invalid_bcd(min) | is_invalid_bcd(sec_tens)
                     | is_invalid_bcd(sec_ones);
  end

  // ---- Stage p1: output registers (reset blanks the display) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      min_segs_p1      <= SEG_DARK;
      sec_tens_segs_p1 <= SEG_DARK;
      sec_ones_segs_p1 <= SEG_DARK;
      bcd_err_p1       <= 1'b0;
    end else begin
      min_segs_p1      <= min_segs_p0;
      sec_tens_segs_p1 <= sec_tens_segs_p0;
      sec_ones_segs_p1 <= sec_ones_segs_p0;
      bcd_err_p1       <= bcd_err_p0;
    end
  end

  assign min_segs      = min_segs_p1;
  assign sec_tens_segs = sec_tens_segs_p1;
  assign sec_ones_segs = sec_ones_segs_p1;
  assign bcd_err       = bcd_err_p1;

endmodule

// File: tb/tb_decodificador_bcd_7seg.sv
// ---------------------------------------------------------------------------
// tb_decodificador_bcd_7seg
//
// Directed testbench for decodificador_bcd_7seg. Inputs change 1 ns after a
// rising edge; outputs are sampled 1 ns after the following rising edge.
// Honors DECODIFICADOR_ACTIVE_LOW_EN to select the expected polarity.
// ---------------------------------------------------------------------------
module tb_decodificador_bcd_7seg;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] min;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [6:0] min_segs;
  logic [6:0] sec_tens_segs;
  logic [6:0] sec_ones_segs;
  logic       bcd_err;

  int vectors     = 0;
  int miscompares = 0;

  decodificador_bcd_7seg dut (
    .clk           (clk),
    .rst           (rst),
    .min           (min),
    .sec_tens      (sec_tens),
    .sec_ones      (sec_ones),
    .min_segs      (min_segs),
    .sec_tens_segs (sec_tens_segs),
    .sec_ones_segs (sec_ones_segs),
    .bcd_err       (bcd_err)
  );

  always #5 clk = ~clk;

  // Hand-written decode table in active-high form, {a..g}.
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b1111110; seg_tab[1]  = 7'b0110000;
    seg_tab[2]  = 7'b1101101; seg_tab[3]  = 7'b1111001;
    seg_tab[4]  = 7'b0110011; seg_tab[5]  = 7'b1011011;
    seg_tab[6]  = 7'b1011111; seg_tab[7]  = 7'b1110000;
    seg_tab[8]  = 7'b1111111; seg_tab[9]  = 7'b1111011;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0000001;
  end

`ifdef DECODIFICADOR_ACTIVE_LOW_EN
  localparam logic [6:0] DARK = 7'b1111111;
  function automatic logic [6:0] pol(input logic [6:0] s); return ~s; endfunction
`else
  localparam logic [6:0] DARK = 7'b0000000;
  function automatic logic [6:0] pol(input logic [6:0] s); return s; endfunction
`endif

  logic [21:0] obs, exp;

  task automatic drive(input logic r, input logic [3:0] m, input logic [3:0] t,
                       input logic [3:0] o);
    rst = r; min = m; sec_tens = t; sec_ones = o;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 4'd8, 4'd8, 4'd8);
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      obs = {min_segs, sec_tens_segs, sec_ones_segs, bcd_err};
      exp = {DARK, DARK, DARK, 1'b0};
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset_cycle%0d got=%h want=%h", c, obs, exp);
      end
    end
    rst = 1'b0;
    tick();
    vectors++;
    obs = {min_segs, sec_tens_segs, sec_ones_segs, bcd_err};
    exp = {pol(7'b1111111), pol(7'b1111111), pol(7'b1111111), 1'b0};
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_release got=%h want=%h", obs, exp);
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 10; v++) begin
      drive(1'b0, 4'(v), 4'(v), 4'(v));
      tick();
      vectors++;
      obs = {min_segs, sec_tens_segs, sec_ones_segs, bcd_err};
      exp = {pol(seg_tab[v]), pol(seg_tab[v]), pol(seg_tab[v]), 1'b0};
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL sweep_%0d got=%h want=%h", v, obs, exp);
      end
    end
  endtask

  task automatic test_independence();
    drive(1'b0, 4'd1, 4'd2, 4'd3);
    tick();
    vectors++;
    obs = {min_segs, sec_tens_segs, sec_ones_segs, bcd_err};
    exp = {pol(7'b0110000), pol(7'b1101101), pol(7'b1111001), 1'b0};
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL independence_123 got=%h want=%h", obs, exp);
    end
    drive(1'b0, 4'd6, 4'd4, 4'd0);
    tick();
    vectors++;
    obs = {min_segs, sec_tens_segs, sec_ones_segs, bcd_err};
    exp = {pol(7'b1011111), pol(7'b0110011), pol(7'b1111110), 1'b0};
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL independence_640 got=%h want=%h", obs, exp);
    end
  endtask

  task automatic test_invalid();
    drive(1'b0, 4'd0, 4'd0, 4'hC);
    tick();
    vectors++;
    obs = {min_segs, sec_tens_segs, sec_ones_segs, bcd_err};
    exp = {pol(7'b1111110), pol(7'b1111110), pol(7'b0000001), 1'b1};
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL invalid_ones_C got=%h want=%h", obs, exp);
    end
    drive(1'b0, 4'd0, 4'd0, 4'd7);
    tick();
    vectors++;
    obs = {min_segs, sec_tens_segs, sec_ones_segs, bcd_err};
    exp = {pol(7'b1111110), pol(7'b1111110), pol(7'b1110000), 1'b0};
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL invalid_recover_7 got=%h want=%h", obs, exp);
    end
  endtask

  // Each channel alone carries an invalid code, changing every cycle.
  task automatic test_back_to_back();
    logic [3:0] m_v [6] = '{4'hA, 4'd2, 4'd3, 4'hF, 4'd9, 4'hD};
    logic [3:0] t_v [6] = '{4'd1, 4'hB, 4'd5, 4'd9, 4'hE, 4'd9};
    logic [3:0] o_v [6] = '{4'd4, 4'd8, 4'hF, 4'd9, 4'd0, 4'd9};
    logic       e_v [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, m_v[k], t_v[k], o_v[k]);
      tick();
      vectors++;
      obs = {min_segs, sec_tens_segs, sec_ones_segs, bcd_err};
      exp = {pol(seg_tab[m_v[k]]), pol(seg_tab[t_v[k]]), pol(seg_tab[o_v[k]]), e_v[k]};
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL back_to_back_%0d got=%h want=%h", k, obs, exp);
      end
    end
    drive(1'b0, 4'd9, 4'd9, 4'd9);
    tick();
    vectors++;
    obs = {min_segs, sec_tens_segs, sec_ones_segs, bcd_err};
    exp = {pol(7'b1111011), pol(7'b1111011), pol(7'b1111011), 1'b0};
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL back_to_back_999 got=%h want=%h", obs, exp);
    end
  endtask

  task automatic test_midrun_reset();
    drive(1'b0, 4'd9, 4'd5, 4'd9);
    tick();
    vectors++;
    obs = {min_segs, sec_tens_segs, sec_ones_segs, bcd_err};
    exp = {pol(7'b1111011), pol(7'b1011011), pol(7'b1111011), 1'b0};
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL midrun_before got=%h want=%h", obs, exp);
    end
    rst = 1'b1;
    tick();
    vectors++;
    obs = {min_segs, sec_tens_segs, sec_ones_segs, bcd_err};
    exp = {DARK, DARK, DARK, 1'b0};
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL midrun_reset got=%h want=%h", obs, exp);
    end
    rst = 1'b0;
    tick();
    vectors++;
    obs = {min_segs, sec_tens_segs, sec_ones_segs, bcd_err};
    exp = {pol(7'b1111011), pol(7'b1011011), pol(7'b1111011), 1'b0};
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL midrun_after got=%h want=%h", obs, exp);
    end
    // Reset wins over an invalid input on the same edge.
    drive(1'b1, 4'hE, 4'd0, 4'd0);
    tick();
    vectors++;
    obs = {min_segs, sec_tens_segs, sec_ones_segs, bcd_err};
    exp = {DARK, DARK, DARK, 1'b0};
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_priority got=%h want=%h", obs, exp);
    end
    rst = 1'b0;
  endtask

  initial begin
    drive(1'b1, 4'd0, 4'd0, 4'd0);
    test_reset();
    test_sweep();
    test_independence();
    test_invalid();
    test_back_to_back();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
